fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single 16-bit write port of the team's FIFO buffer between `NUM_REQ` requesters. Each cycle it selects at most one requesting source, drives the FIFO `wr`/`w_data` pins directly, and returns a one-hot grant to the winner. The arbiter blocks all grants while the FIFO is full. It also supports bounded burst locking, so one source can write a contiguous packet. The block sits between the producer logic and the FIFO `wr`/`w_data`/`full` pins; the FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 172 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the single write port of the FIFO buffer
// between NUM_REQ producers.  Grants are combinational (zero latency).  The
// word is written at the rising edge that ends the grant cycle.  A winning
// source may hold `lock` to keep the port for a packet of up to LOCK_MAX
// words.  While the FIFO reports full, no grant is issued and all
// arbitration state holds.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   req        per-source write request (data held stable while asserted)
//   lock       per-source burst-lock request, sampled with req
//   req_data   packed source data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   full       FIFO full flag
//   gnt        one-hot grant (combinational)
//   wr         FIFO write strobe (OR of gnt)
//   w_data     data of the granted source, 0 when wr=0
//   locked     arbiter currently holds a burst lock
//   owner      index of the lock owner, 0 when not locked
//   stall_cnt  saturating count of cycles with pending requests while full

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int LOCK_MAX   = 16,
    parameter int CNT_WIDTH  = 8,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          wr,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic                          locked,
    output logic [IDX_W-1:0]              owner,
    output logic [CNT_WIDTH-1:0]          stall_cnt
);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] owner_n;
    logic [7:0]     lock_cnt, lock_cnt_n;
    logic [7:0]     lock_cnt_inc;

    logic             found;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] idx;
    logic             grant;
    logic [IDX_W-1:0] sel;

    // Next index in the ring, wrapping at NUM_REQ (which need not be a
    // power of two).
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        if (int'(i) == NUM_REQ - 1)
            return '0;
        else
            return i + IDX_W'(1);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        if (&c)
            return c;
        else
            return c + CNT_WIDTH'(1);
    endfunction

    // Round-robin search starting at ptr.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = wrap_inc(idx);
        end
    end

    // Next-state and grant logic.  full (and reset, so no stray grant is
    // seen while the block is held in reset) freezes everything.
    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        owner_n      = owner;
        lock_cnt_n   = lock_cnt;
        grant        = 1'b0;
        sel          = '0;
        lock_cnt_inc = lock_cnt;

        if (!full && reset) begin
            case (state)
                ARB: begin
                    if (found) begin
                        grant = 1'b1;
                        sel   = winner;
                        ptr_n = wrap_inc(winner);
                        // With LOCK_MAX=1 the first grant already exhausts
                        // the lock, so the arbiter never leaves ARB.
                        if (lock[winner] && LOCK_MAX > 1) begin
                            state_n    = LOCKED;
                            owner_n    = winner;
                            lock_cnt_n = 8'd1;
                        end
                    end
                end
                LOCKED: begin
                    sel          = owner;
                    grant        = req[owner];
                    lock_cnt_inc = lock_cnt + {7'd0, grant};
                    // A req gap with lock held keeps the lock and grants
                    // nobody.
                    if (!lock[owner] || (grant && int'(lock_cnt_inc) >= LOCK_MAX)) begin
                        state_n    = ARB;
                        ptr_n      = wrap_inc(owner);
                        owner_n    = '0;
                        lock_cnt_n = 8'd0;
                    end else begin
                        lock_cnt_n = lock_cnt_inc;
                    end
                end
                default: begin
                    state_n = ARB;
                end
            endcase
        end
    end

    always_comb begin
        gnt    = '0;
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && int'(sel) == i) begin
                gnt[i] = 1'b1;
                w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign wr     = |gnt;
    assign locked = (state == LOCKED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB;
            ptr       <= '0;
            owner     <= '0;
            lock_cnt  <= 8'd0;
            stall_cnt <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            lock_cnt <= lock_cnt_n;
            if (|req && full)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=16,
// LOCK_MAX=4, CNT_WIDTH=8).  Inputs change on the falling edge and outputs
// are sampled 1 ns later, well before the next rising edge.

module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [63:0] req_data;
    logic        full;
    logic [3:0]  gnt;
    logic        wr;
    logic [15:0] w_data;
    logic        locked;
    logic [1:0]  owner;
    logic [7:0]  stall_cnt;

    int errors = 0;
    int checks = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATA_WIDTH(16),
        .LOCK_MAX  (4),
        .CNT_WIDTH (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .lock     (lock),
        .req_data (req_data),
        .full     (full),
        .gnt      (gnt),
        .wr       (wr),
        .w_data   (w_data),
        .locked   (locked),
        .owner    (owner),
        .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        reset = 1'b0;
        req   = 4'b0000;
        lock  = 4'b0000;
        full  = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", wr); end
        checks++; if (w_data !== 16'h0000) begin errors++; $display("FAIL reset_wdata: got %h expected 0000", w_data); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner); end
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g;
        logic [15:0] exp_d;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req  = 4'b1111;
            full = 1'b0;
            #1;
            exp_g = 4'b0001 << c;
            exp_d = 16'haa00 + 16'(c);
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt, exp_g); end
            checks++; if (w_data !== exp_d) begin errors++; $display("FAIL rr_wdata[%0d]: got %h expected %h", c, w_data, exp_d); end
            checks++; if (wr !== 1'b1) begin errors++; $display("FAIL rr_wr[%0d]: got %b expected 1", c, wr); end
        end
    endtask

    task automatic test_full_block();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req  = 4'b0101;
            full = 1'b1;
            #1;
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL full_gnt[%0d]: got %b expected 0000", c, gnt); end
            checks++; if (wr !== 1'b0) begin errors++; $display("FAIL full_wr[%0d]: got %b expected 0", c, wr); end
        end
        @(negedge clk);
        full = 1'b0;
        #1;
        checks++; if (stall_cnt !== 8'd5) begin errors++; $display("FAIL full_stall: got %0d expected 5", stall_cnt); end
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL full_resume_gnt: got %b expected 0001", gnt); end
        checks++; if (w_data !== 16'haa00) begin errors++; $display("FAIL full_resume_wdata: got %h expected aa00", w_data); end
        @(negedge clk);
        req = 4'b0000;
    endtask

    // ptr=1 on entry: source 2 wins and locks, source 0 waits.
    task automatic test_lock_burst();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req  = 4'b0101;
            lock = 4'b0100;
            #1;
            checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL burst_gnt[%0d]: got %b expected 0100", c, gnt); end
            if (c > 0) begin
                checks++; if (locked !== 1'b1) begin errors++; $display("FAIL burst_locked[%0d]: got %b expected 1", c, locked); end
                checks++; if (owner !== 2'd2) begin errors++; $display("FAIL burst_owner[%0d]: got %0d expected 2", c, owner); end
            end
        end
        @(negedge clk);
        lock = 4'b0000;
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL burst_final_gnt: got %b expected 0100", gnt); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL burst_final_locked: got %b expected 1", locked); end
        @(negedge clk);
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL burst_after_gnt: got %b expected 0001", gnt); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL burst_after_locked: got %b expected 0", locked); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL burst_after_owner: got %0d expected 0", owner); end
        @(negedge clk);
        req = 4'b0000;
    endtask

    // ptr=1 on entry: source 1 locks, source 3 competes; LOCK_MAX=4.
    task automatic test_lock_max();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req  = 4'b1010;
            lock = 4'b0010;
            #1;
            checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL lmax_gnt[%0d]: got %b expected 0010", c, gnt); end
            if (c > 0) begin
                checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lmax_locked[%0d]: got %b expected 1", c, locked); end
            end
        end
        @(negedge clk);
        #1;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL lmax_release_gnt: got %b expected 1000", gnt); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lmax_release_locked: got %b expected 0", locked); end
        checks++; if (w_data !== 16'haa03) begin errors++; $display("FAIL lmax_release_wdata: got %h expected aa03", w_data); end
        @(negedge clk);
        req  = 4'b0000;
        lock = 4'b0000;
    endtask

    // ptr=0 on entry: source 2 locks, then pauses while source 0 requests.
    task automatic test_lock_gap();
        @(negedge clk);
        req  = 4'b0100;
        lock = 4'b0100;
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL gap_first_gnt: got %b expected 0100", gnt); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            req = 4'b0001;
            #1;
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL gap_gnt[%0d]: got %b expected 0000", c, gnt); end
            checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gap_locked[%0d]: got %b expected 1", c, locked); end
        end
        @(negedge clk);
        req = 4'b0101;
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL gap_resume_gnt: got %b expected 0100", gnt); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gap_resume_locked: got %b expected 1", locked); end
        // Lock dropped while the owner is idle: release without a grant.
        @(negedge clk);
        req  = 4'b0001;
        lock = 4'b0000;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL gap_drop_gnt: got %b expected 0000", gnt); end
        @(negedge clk);
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL gap_after_gnt: got %b expected 0001", gnt); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL gap_after_locked: got %b expected 0", locked); end
        @(negedge clk);
        req = 4'b0000;
    endtask

    // ptr=1 on entry: source 1 locks, then reset hits mid-burst.
    task automatic test_reset_mid_lock();
        @(negedge clk);
        req  = 4'b0010;
        lock = 4'b0010;
        @(negedge clk);
        #1;
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rstlk_locked_pre: got %b expected 1", locked); end
        checks++; if (owner !== 2'd1) begin errors++; $display("FAIL rstlk_owner_pre: got %0d expected 1", owner); end
        #2;
        reset = 1'b0;
        req   = 4'b0011;
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rstlk_locked: got %b expected 0", locked); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL rstlk_owner: got %0d expected 0", owner); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rstlk_gnt: got %b expected 0000", gnt); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL rstlk_wr: got %b expected 0", wr); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rstlk_after_gnt: got %b expected 0001", gnt); end
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL rstlk_stall: got %0d expected 0", stall_cnt); end
        @(negedge clk);
        req  = 4'b0000;
        lock = 4'b0000;
    endtask

    task automatic test_stall_saturate();
        @(negedge clk);
        req  = 4'b0001;
        full = 1'b1;
        repeat (260) @(negedge clk);
        #1;
        checks++; if (stall_cnt !== 8'd255) begin errors++; $display("FAIL sat_stall: got %0d expected 255", stall_cnt); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL sat_gnt: got %b expected 0000", gnt); end
        checks++; if (w_data !== 16'h0000) begin errors++; $display("FAIL sat_wdata: got %h expected 0000", w_data); end
        @(negedge clk);
        req  = 4'b0000;
        full = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++)
            req_data[i*16 +: 16] = 16'haa00 + 16'(i);
        test_reset();
        test_round_robin();
        test_full_block();
        test_lock_burst();
        test_lock_max();
        test_lock_gap();
        test_reset_mid_lock();
        test_stall_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
